// File: rtl/board_io_tester_if.sv
`timescale 1ns/1ps
// Board pin bundle for board_io_tester: switches and buttons in, LEDs and display out.
// Latency: none, wires only.
// Backpressure: none, pin levels only.
// Signals: sw/btn are raw asynchronous board inputs; led/which/seg/enable/mode drive the board.
// Modports: master = board side (drives sw/btn), slave = tester side (drives led/display/mode).
interface board_io_tester_if #(
   parameter int SW_W    = 32,
   parameter int NUM_BTN = 6
);
   logic [SW_W-1:0]    sw;      // switch levels, asynchronous
   logic [NUM_BTN-1:0] btn;     // raw button levels, asynchronous, active-high
   logic [SW_W-1:0]    led;     // LED drive, 1 = lit
   logic [2:0]         which;   // digit select index
   logic [7:0]         seg;     // [6:0] = g..a, [7] = dp, 1 = lit
   logic               enable;  // display enable
   logic [1:0]         mode;    // 0 = PASS, 1 = WALK, 2 = COUNT

   modport master (output sw, btn, input led, which, seg, enable, mode);
   modport slave  (input sw, btn, output led, which, seg, enable, mode);
endinterface

// File: rtl/board_io_tester.sv
`timescale 1ns/1ps
// Board bring-up tester: synchronised/debounced buttons, PASS/WALK/COUNT modes, freeze, hex scanner.
// Latency: sw to led 2 cycles in PASS; button to event 2 sync + DEBOUNCE_CYCLES; seg 1 cycle after which.
// Backpressure: none; free-running pin-level block, every input is sampled each cycle.
// Ports: clk, rst (synchronous, active-high); io (board_io_tester_if.slave) carries sw/btn in and
//        led/which/seg/enable/mode out.
// Optional: define BOARD_LAMP_TEST_EN for an LAMP_CYCLES-long lamp test after reset.
module board_io_tester #(
   parameter int SW_W            = 32,
   parameter int NUM_BTN         = 6,
   parameter int NUM_DIGITS      = 8,
   parameter int DEBOUNCE_CYCLES = 100000,
   parameter int SCAN_CYCLES     = 50000,
   parameter int WALK_CYCLES     = 5000000,
   parameter int LAMP_CYCLES     = 25000000
) (
   input  logic              clk,
   input  logic              rst,
   board_io_tester_if.slave  io
);

   localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int SC_W   = $clog2(SCAN_CYCLES + 1);
   localparam int WK_W   = $clog2(WALK_CYCLES + 1);
   localparam int WP_W   = (SW_W > 1) ? $clog2(SW_W) : 1;
   localparam int PC_W   = $clog2(NUM_BTN + 1);
   localparam int DISP_W = 4 * NUM_DIGITS;
   // Common width wide enough to zero-extend sw, counter and walk position into either sink.
   localparam int XW0    = (SW_W > DISP_W) ? SW_W : DISP_W;
   localparam int XW     = (XW0 > 16) ? XW0 : 16;

   localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [SC_W-1:0] SC_LAST  = SC_W'(SCAN_CYCLES - 1);
   localparam logic [WK_W-1:0] WK_LAST  = WK_W'(WALK_CYCLES - 1);
   localparam logic [WP_W-1:0] WP_LAST  = WP_W'(SW_W - 1);
   localparam logic [2:0]      DIG_LAST = 3'(NUM_DIGITS - 1);

   if (NUM_BTN < 3 || NUM_DIGITS < 2 || NUM_DIGITS > 8 || (NUM_DIGITS & (NUM_DIGITS - 1)) != 0 ||
       DEBOUNCE_CYCLES < 1 || SCAN_CYCLES < 1 || WALK_CYCLES < 1 || LAMP_CYCLES < 1) begin : g_bad_param
      $error("board_io_tester: illegal parameter set");
   end

   typedef enum logic [1:0] {
      MODE_PASS  = 2'd0,
      MODE_WALK  = 2'd1,
      MODE_COUNT = 2'd2
   } mode_e;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
      endcase
   endfunction

   // State
   logic [SW_W-1:0]    sw_s1_q, sw_s2_q;
   logic [NUM_BTN-1:0] btn_s1_q, btn_s2_q;
   logic [NUM_BTN-1:0] btn_acc_q, btn_acc_d;
   logic [DB_W-1:0]    db_cnt_q [NUM_BTN];
   logic [DB_W-1:0]    db_cnt_d [NUM_BTN];
   mode_e              mode_q, mode_d;
   logic               enable_q, enable_d;
   logic               freeze_q, freeze_d;
   logic [DISP_W-1:0]  held_q, held_d;
   logic [15:0]        press_cnt_q, press_cnt_d;
   logic [WP_W-1:0]    walk_pos_q, walk_pos_d;
   logic [WK_W-1:0]    walk_tmr_q, walk_tmr_d;
   logic [SC_W-1:0]    scan_tmr_q, scan_tmr_d;
   logic [2:0]         which_q, which_d;
   logic [7:0]         seg_q, seg_d;

   // Combinational helpers
   logic               lamp_on;
   logic [NUM_BTN-1:0] evt_raw, evt;
   logic [PC_W-1:0]    evt_num;
   logic [XW-1:0]      sw_x, cnt_x, pos_x;
   logic [DISP_W-1:0]  live_data, disp_data;
   logic [3:0]         nib;
   logic [SW_W-1:0]    led_c;

`ifdef BOARD_LAMP_TEST_EN
   localparam int LP_W = $clog2(LAMP_CYCLES + 1);
   localparam logic [LP_W-1:0] LP_LAST = LP_W'(LAMP_CYCLES - 1);
   logic [LP_W-1:0] lamp_cnt_q, lamp_cnt_d;
   logic            lamp_on_q, lamp_on_d;

   always_comb begin
      lamp_cnt_d = lamp_cnt_q;
      lamp_on_d  = lamp_on_q;
      if (lamp_on_q) begin
         if (lamp_cnt_q == LP_LAST) begin
            lamp_on_d  = 1'b0;
            lamp_cnt_d = '0;
         end else begin
            lamp_cnt_d = lamp_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lamp_cnt_q <= '0;
         lamp_on_q  <= 1'b1;
      end else begin
         lamp_cnt_q <= lamp_cnt_d;
         lamp_on_q  <= lamp_on_d;
      end
   end

   assign lamp_on = lamp_on_q;
`else
   assign lamp_on = 1'b0;
`endif

   always_comb begin
      btn_acc_d   = btn_acc_q;
      db_cnt_d    = db_cnt_q;
      mode_d      = mode_q;
      enable_d    = enable_q;
      freeze_d    = freeze_q;
      held_d      = held_q;
      walk_pos_d  = walk_pos_q;
      walk_tmr_d  = walk_tmr_q;
      scan_tmr_d  = scan_tmr_q;
      which_d     = which_q;
      evt_raw     = '0;
      evt_num     = '0;
      nib         = '0;
      led_c       = '0;
      live_data   = '0;

      // Debounce: count consecutive disagreeing samples, accept the new level on the last one.
      for (int b = 0; b < NUM_BTN; b++) begin
         if (btn_s2_q[b] != btn_acc_q[b]) begin
            if (db_cnt_q[b] == DB_LAST) begin
               btn_acc_d[b] = ~btn_acc_q[b];
               db_cnt_d[b]  = '0;
               evt_raw[b]   = ~btn_acc_q[b];   // rising accepted level only
            end else begin
               db_cnt_d[b]  = db_cnt_q[b] + 1'b1;
            end
         end else begin
            db_cnt_d[b] = '0;
         end
      end
      evt = evt_raw & {NUM_BTN{~lamp_on}};

      for (int b = 0; b < NUM_BTN; b++) begin
         evt_num = evt_num + PC_W'(evt[b]);
      end
      press_cnt_d = press_cnt_q + 16'(evt_num);

      if (evt[0]) enable_d = ~enable_q;

      if (evt[1]) begin
         case (mode_q)
            MODE_PASS: mode_d = MODE_WALK;
            MODE_WALK: mode_d = MODE_COUNT;
            default:   mode_d = MODE_PASS;
         endcase
      end

      // A mode change releases a frozen display; otherwise btn[2] toggles freeze.
      if (evt[1] && freeze_q) freeze_d = 1'b0;
      else if (evt[2])        freeze_d = ~freeze_q;

      // Walk position only runs while staying in WALK; entering or leaving restarts it.
      if (mode_d != MODE_WALK || mode_q != MODE_WALK) begin
         walk_pos_d = '0;
         walk_tmr_d = '0;
      end else if (walk_tmr_q == WK_LAST) begin
         walk_tmr_d = '0;
         walk_pos_d = (walk_pos_q == WP_LAST) ? '0 : walk_pos_q + 1'b1;
      end else begin
         walk_tmr_d = walk_tmr_q + 1'b1;
      end

      sw_x  = '0;
      sw_x[SW_W-1:0] = sw_s2_q;
      cnt_x = '0;
      cnt_x[15:0] = press_cnt_q;
      pos_x = '0;
      pos_x[WP_W-1:0] = walk_pos_q;

      case (mode_q)
         MODE_WALK: begin
            live_data = pos_x[DISP_W-1:0];
            led_c     = {{(SW_W-1){1'b0}}, 1'b1} << walk_pos_q;
         end
         MODE_COUNT: begin
            live_data = cnt_x[DISP_W-1:0];
            led_c     = cnt_x[SW_W-1:0];
         end
         default: begin
            live_data = sw_x[DISP_W-1:0];
            led_c     = sw_s2_q;
         end
      endcase
      if (lamp_on) led_c = '1;

      // Capture the display value of the cycle on which freeze becomes set.
      if (freeze_d && !freeze_q) held_d = live_data;
      disp_data = freeze_q ? held_q : live_data;

      if (scan_tmr_q == SC_LAST) begin
         scan_tmr_d = '0;
         which_d    = (which_q == DIG_LAST) ? 3'd0 : which_q + 3'd1;
      end else begin
         scan_tmr_d = scan_tmr_q + 1'b1;
      end

      for (int d = 0; d < NUM_DIGITS; d++) begin
         if (which_q == 3'(d)) nib = disp_data[d*4 +: 4];
      end
      seg_d = enable_q ? {1'b0, hex7(nib)} : 8'h00;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sw_s1_q     <= '0;
         sw_s2_q     <= '0;
         btn_s1_q    <= '0;
         btn_s2_q    <= '0;
         btn_acc_q   <= '0;
         for (int b = 0; b < NUM_BTN; b++) db_cnt_q[b] <= '0;
         mode_q      <= MODE_PASS;
         enable_q    <= 1'b1;
         freeze_q    <= 1'b0;
         held_q      <= '0;
         press_cnt_q <= '0;
         walk_pos_q  <= '0;
         walk_tmr_q  <= '0;
         scan_tmr_q  <= '0;
         which_q     <= '0;
         seg_q       <= '0;
      end else begin
         sw_s1_q     <= io.sw;
         sw_s2_q     <= sw_s1_q;
         btn_s1_q    <= io.btn;
         btn_s2_q    <= btn_s1_q;
         btn_acc_q   <= btn_acc_d;
         db_cnt_q    <= db_cnt_d;
         mode_q      <= mode_d;
         enable_q    <= enable_d;
         freeze_q    <= freeze_d;
         held_q      <= held_d;
         press_cnt_q <= press_cnt_d;
         walk_pos_q  <= walk_pos_d;
         walk_tmr_q  <= walk_tmr_d;
         scan_tmr_q  <= scan_tmr_d;
         which_q     <= which_d;
         seg_q       <= seg_d;
      end
   end

   assign io.led    = led_c;
   assign io.which  = which_q;
   assign io.seg    = lamp_on ? 8'hFF : seg_q;
   assign io.enable = enable_q | lamp_on;
   assign io.mode   = mode_q;

endmodule

// File: tb/tb_board_io_tester.sv
`timescale 1ns/1ps
// Directed bench for board_io_tester with short debounce/scan/walk timings.
module tb_board_io_tester;
   localparam int SW_W = 32;
   localparam int NB   = 6;
   localparam int LAMP = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   board_io_tester_if #(.SW_W(SW_W), .NUM_BTN(NB)) bif ();

   board_io_tester #(
      .SW_W(SW_W), .NUM_BTN(NB), .NUM_DIGITS(8), .DEBOUNCE_CYCLES(4),
      .SCAN_CYCLES(2), .WALK_CYCLES(3), .LAMP_CYCLES(LAMP)
   ) dut (
      .clk(clk),
      .rst(rst),
      .io (bif)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc   = 0;     // rising edges with rst low since the last reset
   logic [15:0] cnt_exp = '0;

   function automatic logic [6:0] hex7_ref(input logic [3:0] n);
      logic [6:0] t [16];
      t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      return t[n];
   endfunction

   function automatic logic [7:0] seg_ref(input logic [31:0] data, input int idx);
      logic [3:0] n;
      n = data[idx*4 +: 4];
      return {1'b0, hex7_ref(n)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      if (!rst) cyc = cyc + 1;
   endtask

   task automatic press_hold(input logic [NB-1:0] m);
      bif.btn = m;
      repeat (6) tick();
   endtask

   task automatic release_btn();
      bif.btn = '0;
      repeat (8) tick();
   endtask

   task automatic test_reset();
      logic [31:0] rl;
      logic [7:0]  rs;
`ifdef BOARD_LAMP_TEST_EN
      rl = 32'hFFFF_FFFF; rs = 8'hFF;
`else
      rl = 32'h0; rs = 8'h00;
`endif
      rst = 1'b1; bif.sw = '0; bif.btn = '0;
      repeat (3) tick();
      n_cmp++; if (bif.led !== rl)      begin n_bad++; $display("FAIL rst_led got=%h want=%h", bif.led, rl); end
      n_cmp++; if (bif.which !== 3'd0)  begin n_bad++; $display("FAIL rst_which got=%0d want=0", bif.which); end
      n_cmp++; if (bif.seg !== rs)      begin n_bad++; $display("FAIL rst_seg got=%h want=%h", bif.seg, rs); end
      n_cmp++; if (bif.enable !== 1'b1) begin n_bad++; $display("FAIL rst_enable got=%b want=1", bif.enable); end
      n_cmp++; if (bif.mode !== 2'd0)   begin n_bad++; $display("FAIL rst_mode got=%0d want=0", bif.mode); end
      rst = 1'b0;
      cyc = 0;
`ifdef BOARD_LAMP_TEST_EN
      repeat (LAMP) tick();
`endif
   endtask

   task automatic test_pass();
      logic [31:0] d;
      d = 32'h1234ABCD;
      bif.sw = d;
      tick();
      n_cmp++; if (bif.led !== 32'h0) begin n_bad++; $display("FAIL pass_led_early got=%h want=0", bif.led); end
      tick();
      n_cmp++; if (bif.led !== d) begin n_bad++; $display("FAIL pass_led got=%h want=%h", bif.led, d); end
      for (int i = 0; i < 16; i++) begin
         tick();
         n_cmp++;
         if (bif.which !== 3'((cyc / 2) % 8)) begin
            n_bad++; $display("FAIL pass_which cyc=%0d got=%0d want=%0d", cyc, bif.which, (cyc / 2) % 8);
         end
         n_cmp++;
         if (bif.seg !== seg_ref(d, ((cyc - 1) / 2) % 8)) begin
            n_bad++; $display("FAIL pass_seg cyc=%0d got=%h want=%h", cyc, bif.seg, seg_ref(d, ((cyc - 1) / 2) % 8));
         end
      end
   endtask

   task automatic test_enable();
      bif.btn = 6'b000001; tick();
      bif.btn = 6'b000000; tick();
      bif.btn = 6'b000001;
      repeat (5) tick();
      n_cmp++; if (bif.enable !== 1'b1) begin n_bad++; $display("FAIL en_early got=%b want=1", bif.enable); end
      tick();
      n_cmp++; if (bif.enable !== 1'b0) begin n_bad++; $display("FAIL en_toggle got=%b want=0", bif.enable); end
      tick();
      release_btn();
      cnt_exp = cnt_exp + 16'd1;
      n_cmp++; if (bif.enable !== 1'b0) begin n_bad++; $display("FAIL en_release got=%b want=0", bif.enable); end
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++; if (bif.seg !== 8'h00) begin n_bad++; $display("FAIL en_seg_off got=%h want=00", bif.seg); end
         n_cmp++;
         if (bif.which !== 3'((cyc / 2) % 8)) begin
            n_bad++; $display("FAIL en_which cyc=%0d got=%0d want=%0d", cyc, bif.which, (cyc / 2) % 8);
         end
      end
      press_hold(6'b000001);
      cnt_exp = cnt_exp + 16'd1;
      n_cmp++; if (bif.enable !== 1'b1) begin n_bad++; $display("FAIL en_restore got=%b want=1", bif.enable); end
      release_btn();
   endtask

   task automatic test_walk();
      press_hold(6'b000010);
      cnt_exp = cnt_exp + 16'd1;
      bif.btn = '0;
      n_cmp++; if (bif.mode !== 2'd1)   begin n_bad++; $display("FAIL walk_mode got=%0d want=1", bif.mode); end
      n_cmp++; if (bif.led !== 32'h1)   begin n_bad++; $display("FAIL walk_led0 got=%h want=1", bif.led); end
      repeat (3) tick();
      n_cmp++; if (bif.led !== 32'h2)   begin n_bad++; $display("FAIL walk_led1 got=%h want=2", bif.led); end
      repeat (3) tick();
      n_cmp++; if (bif.led !== 32'h4)   begin n_bad++; $display("FAIL walk_led2 got=%h want=4", bif.led); end
      repeat (87) tick();
      n_cmp++; if (bif.led !== 32'h8000_0000) begin n_bad++; $display("FAIL walk_led31 got=%h want=80000000", bif.led); end
      repeat (3) tick();
      n_cmp++; if (bif.led !== 32'h1)   begin n_bad++; $display("FAIL walk_wrap got=%h want=1", bif.led); end
      press_hold(6'b000010);
      cnt_exp = cnt_exp + 16'd1;
      n_cmp++; if (bif.mode !== 2'd2)   begin n_bad++; $display("FAIL count_mode got=%0d want=2", bif.mode); end
      n_cmp++; if (bif.led !== {16'h0, cnt_exp}) begin n_bad++; $display("FAIL count_entry got=%h want=%h", bif.led, cnt_exp); end
      release_btn();
   endtask

   task automatic test_count();
      press_hold(6'b011000);
      cnt_exp = cnt_exp + 16'd2;
      n_cmp++; if (bif.led !== {16'h0, cnt_exp}) begin n_bad++; $display("FAIL count_dual got=%h want=%h", bif.led, cnt_exp); end
      release_btn();
      force dut.press_cnt_q = 16'hFFFF;
      tick();
      release dut.press_cnt_q;
      tick();
      n_cmp++; if (bif.led !== 32'h0000_FFFF) begin n_bad++; $display("FAIL count_preload got=%h want=0000ffff", bif.led); end
      press_hold(6'b100000);
      n_cmp++; if (bif.led !== 32'h0) begin n_bad++; $display("FAIL count_wrap got=%h want=0", bif.led); end
      release_btn();
      cnt_exp = 16'd0;
   endtask

   task automatic test_freeze();
      logic [31:0] d;
      d = 32'h1234ABCD;
      press_hold(6'b000010);
      cnt_exp = cnt_exp + 16'd1;
      n_cmp++; if (bif.mode !== 2'd0) begin n_bad++; $display("FAIL frz_pass_mode got=%0d want=0", bif.mode); end
      n_cmp++; if (bif.led !== d)     begin n_bad++; $display("FAIL frz_pass_led got=%h want=%h", bif.led, d); end
      release_btn();
      press_hold(6'b000100);
      cnt_exp = cnt_exp + 16'd1;
      release_btn();
      bif.sw = '0;
      tick(); tick();
      n_cmp++; if (bif.led !== 32'h0) begin n_bad++; $display("FAIL frz_led_live got=%h want=0", bif.led); end
      for (int i = 0; i < 16; i++) begin
         tick();
         n_cmp++;
         if (bif.seg !== seg_ref(d, ((cyc - 1) / 2) % 8)) begin
            n_bad++; $display("FAIL frz_seg cyc=%0d got=%h want=%h", cyc, bif.seg, seg_ref(d, ((cyc - 1) / 2) % 8));
         end
      end
      press_hold(6'b000010);
      cnt_exp = cnt_exp + 16'd1;
      n_cmp++; if (bif.mode !== 2'd1) begin n_bad++; $display("FAIL frz_walk_mode got=%0d want=1", bif.mode); end
      tick(); tick();
      n_cmp++; if (bif.seg !== 8'h3F) begin n_bad++; $display("FAIL frz_cleared_a got=%h want=3f", bif.seg); end
      tick();
      n_cmp++; if (bif.seg !== 8'h3F) begin n_bad++; $display("FAIL frz_cleared_b got=%h want=3f", bif.seg); end
      release_btn();
      press_hold(6'b000010);
      cnt_exp = cnt_exp + 16'd1;
      n_cmp++; if (bif.led !== {16'h0, cnt_exp}) begin n_bad++; $display("FAIL count_total got=%h want=%h", bif.led, cnt_exp); end
      release_btn();
   endtask

`ifdef BOARD_LAMP_TEST_EN
   task automatic test_lamp();
      rst = 1'b1; bif.sw = 32'h0000_00F0; bif.btn = 6'b000001;
      repeat (2) tick();
      rst = 1'b0;
      tick();
      n_cmp++; if (bif.led !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL lamp_led_first got=%h want=ffffffff", bif.led); end
      n_cmp++; if (bif.seg !== 8'hFF)         begin n_bad++; $display("FAIL lamp_seg_first got=%h want=ff", bif.seg); end
      repeat (8) tick();
      n_cmp++; if (bif.led !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL lamp_led_last got=%h want=ffffffff", bif.led); end
      n_cmp++; if (bif.seg !== 8'hFF)         begin n_bad++; $display("FAIL lamp_seg_last got=%h want=ff", bif.seg); end
      tick();
      n_cmp++; if (bif.led !== 32'h0000_00F0) begin n_bad++; $display("FAIL lamp_end_led got=%h want=000000f0", bif.led); end
      repeat (2) tick();
      n_cmp++; if (bif.enable !== 1'b1) begin n_bad++; $display("FAIL lamp_btn_ignored got=%b want=1", bif.enable); end
      n_cmp++; if (bif.mode !== 2'd0)   begin n_bad++; $display("FAIL lamp_mode got=%0d want=0", bif.mode); end
      release_btn();
   endtask
`endif

   initial begin
      bif.sw  = '0;
      bif.btn = '0;
      test_reset();
      test_pass();
      test_enable();
      test_walk();
      test_count();
      test_freeze();
`ifdef BOARD_LAMP_TEST_EN
      test_lamp();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
